// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Multi-cycle control FSM for the register-file/ALU datapath. Fetches one
//   32-bit instruction at a time over a valid/ready port, then spends one
//   EXEC (ALU settle) cycle and one WB (write-back) cycle driving the
//   datapath controls decoded from the latched instruction register.
//
// Ports
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   start                : leave IDLE/HALT and restart fetching at START_ADDR
//   instr_valid/ready    : instruction handshake (ready only in FETCH)
//   instr_data           : instruction word {op,alu,rd,rs2,rs1|imm}
//   instr_addr           : program counter of the requested instruction
//   read_reg_num1/2,
//   write_reg, alu_control,
//   immediate, imm_ctrl,
//   lw_ctrl, sw_ctrl     : datapath controls, nonzero only in EXEC/WB
//   write_enable, mode   : high only in WB
//   busy, halted         : status (busy = not IDLE/HALT)
//   illegal_op           : sticky flag for an unknown opcode
//   retired_cnt          : saturating count of retired instructions
module datapath_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [4:0]        read_reg_num1,
  output logic [4:0]        read_reg_num2,
  output logic [4:0]        write_reg,
  output logic [2:0]        alu_control,
  output logic [15:0]       immediate,
  output logic              imm_ctrl,
  output logic              lw_ctrl,
  output logic              sw_ctrl,
  output logic              write_enable,
  output logic              mode,
  output logic              busy,
  output logic              halted,
  output logic              illegal_op,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'b000;
  localparam logic [2:0] OP_IMM  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

  state_t             state, state_nxt;
  logic [31:0]        ir;
  logic [ADDR_W-1:0]  pc;
  logic               illegal_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         fetch_op;
  logic [2:0]         ir_op;
  logic               accept;
  logic               fetch_legal;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fetch_op    = instr_data[31:29];
  assign ir_op       = ir[31:29];
  assign accept      = (state == S_FETCH) && instr_valid;
  assign fetch_legal = (fetch_op == OP_ALU) || (fetch_op == OP_IMM) ||
                       (fetch_op == OP_LW)  || (fetch_op == OP_SW);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (accept) begin
          if (fetch_legal)              state_nxt = S_EXEC;
          else if (fetch_op == OP_HALT) state_nxt = S_HALT;
        end
      end
      S_EXEC:  state_nxt = S_WB;
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= START_PC;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc        <= START_PC;
            illegal_q <= 1'b0;
          end
        end
        S_FETCH: begin
          // Unknown opcodes are skipped in place: flag, step PC, keep fetching.
          if (accept && !fetch_legal && (fetch_op != OP_HALT)) begin
            illegal_q <= 1'b1;
            pc        <= pc + ADDR_W'(1);
          end
        end
        S_WB: begin
          pc    <= pc + ADDR_W'(1);
          cnt_q <= sat_inc(cnt_q);
        end
        default: ;
      endcase
    end
  end

  // Instruction register: pure data, only meaningful while in EXEC/WB.
  always_ff @(posedge clock) begin
    if (accept) ir <= instr_data;
  end

  always_comb begin
    read_reg_num1 = '0;
    read_reg_num2 = '0;
    write_reg     = '0;
    alu_control   = '0;
    immediate     = '0;
    imm_ctrl      = 1'b0;
    lw_ctrl       = 1'b0;
    sw_ctrl       = 1'b0;
    if ((state == S_EXEC) || (state == S_WB)) begin
      read_reg_num1 = ir[15:11];
      read_reg_num2 = ir[20:16];
      write_reg     = ir[25:21];
      alu_control   = ir[28:26];
      case (ir_op)
        OP_IMM: begin
          imm_ctrl  = 1'b1;
          immediate = ir[15:0];
        end
        OP_LW:   lw_ctrl = 1'b1;
        OP_SW:   sw_ctrl = 1'b1;
        default: ;
      endcase
    end
  end

  assign write_enable = (state == S_WB);
  assign mode         = (state == S_WB);
  assign instr_ready  = (state == S_FETCH);
  assign busy         = (state != S_IDLE) && (state != S_HALT);
  assign halted       = (state == S_HALT);
  assign illegal_op   = illegal_q;
  assign retired_cnt  = cnt_q;
  assign instr_addr   = pc;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a main instance (ADDR_W=8, CNT_W=16) and a
// small instance (ADDR_W=2, CNT_W=3) for PC wrap and counter saturation.
module tb_datapath_sequencer;

  logic        clock;
  logic        reset, start, instr_valid;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic [7:0]  instr_addr;
  logic [4:0]  read_reg_num1, read_reg_num2, write_reg;
  logic [2:0]  alu_control;
  logic [15:0] immediate;
  logic        imm_ctrl, lw_ctrl, sw_ctrl, write_enable, mode;
  logic        busy, halted, illegal_op;
  logic [15:0] retired_cnt;

  logic        b_reset, b_start, b_valid;
  logic [31:0] b_data;
  logic        b_ready;
  logic [1:0]  b_addr;
  logic [4:0]  b_rr1, b_rr2, b_wr;
  logic [2:0]  b_alu;
  logic [15:0] b_imm;
  logic        b_ic, b_lc, b_sc, b_we, b_mode, b_busy, b_halted, b_ill;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  logic [44:0] exp_q[$];
  logic [44:0] obs_q[$];
  logic [36:0] ctrl_vec;

  datapath_sequencer #(.ADDR_W(8), .START_ADDR(0), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_data(instr_data), .instr_addr(instr_addr),
    .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .immediate(immediate),
    .imm_ctrl(imm_ctrl), .lw_ctrl(lw_ctrl), .sw_ctrl(sw_ctrl),
    .write_enable(write_enable), .mode(mode), .busy(busy), .halted(halted),
    .illegal_op(illegal_op), .retired_cnt(retired_cnt)
  );

  datapath_sequencer #(.ADDR_W(2), .START_ADDR(0), .CNT_W(3)) dut2 (
    .clock(clock), .reset(b_reset), .start(b_start), .instr_valid(b_valid),
    .instr_ready(b_ready), .instr_data(b_data), .instr_addr(b_addr),
    .read_reg_num1(b_rr1), .read_reg_num2(b_rr2), .write_reg(b_wr),
    .alu_control(b_alu), .immediate(b_imm), .imm_ctrl(b_ic), .lw_ctrl(b_lc),
    .sw_ctrl(b_sc), .write_enable(b_we), .mode(b_mode), .busy(b_busy),
    .halted(b_halted), .illegal_op(b_ill), .retired_cnt(b_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ctrl_vec = {read_reg_num1, read_reg_num2, write_reg, alu_control,
                     immediate, imm_ctrl, lw_ctrl, sw_ctrl};

  // Every write_enable cycle of the main instance is logged as one retire.
  always @(negedge clock) begin
    if (write_enable === 1'b1)
      obs_q.push_back({write_reg, read_reg_num1, read_reg_num2, alu_control,
                       immediate, imm_ctrl, lw_ctrl, sw_ctrl, instr_addr});
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] alu,
                                      input logic [4:0] rd, input logic [4:0] rs2,
                                      input logic [15:0] low);
    return {op, alu, rd, rs2, low};
  endfunction

  // Expected datapath controls while retiring word w fetched from pc.
  function automatic logic [44:0] exp_rec(input logic [31:0] w, input logic [7:0] pc);
    logic [2:0]  op;
    logic        ic, lc, sc;
    logic [15:0] imm;
    op  = w[31:29];
    ic  = (op == 3'b001);
    lc  = (op == 3'b010);
    sc  = (op == 3'b011);
    imm = ic ? w[15:0] : 16'h0000;
    return {w[25:21], w[15:11], w[20:16], w[28:26], imm, ic, lc, sc, pc};
  endfunction

  // Present w until the sequencer takes it; called and returns at a negedge.
  task automatic send(input logic [31:0] w, output bit to);
    to = 1'b1;
    instr_data  = w;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(negedge clock);
    end
    @(negedge clock);
    instr_valid = 1'b0;
    instr_data  = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || instr_ready !== 1'b0 || halted !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("FAIL reset_status got busy=%b rdy=%b halt=%b ill=%b want 0000", busy, instr_ready, halted, illegal_op); end
    checks++; if (ctrl_vec !== 37'h0 || write_enable !== 1'b0 || mode !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %h we=%b mode=%b want 0", ctrl_vec, write_enable, mode); end
    checks++; if (instr_addr !== 8'h00 || retired_cnt !== 16'h0) begin errors++; $display("FAIL reset_pc_cnt got pc=%h cnt=%h want 00 0000", instr_addr, retired_cnt); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL idle_no_start got busy=%b rdy=%b want 0 0", busy, instr_ready); end
  endtask

  task automatic test_alu();
    logic [31:0] w;
    bit to;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (instr_ready !== 1'b1 || instr_addr !== 8'h00) begin errors++; $display("FAIL alu_fetch got rdy=%b pc=%h want 1 00", instr_ready, instr_addr); end
    w = enc(3'b000, 3'b010, 5'd3, 5'd2, {5'd1, 11'd0});
    exp_q.push_back(exp_rec(w, 8'h00));
    send(w, to);
    checks++; if (to) begin errors++; $display("FAIL alu_handshake got timeout want accept"); end
    checks++; if (write_enable !== 1'b0 || mode !== 1'b0 || write_reg !== 5'd3 || alu_control !== 3'b010) begin errors++; $display("FAIL alu_exec got we=%b mode=%b wr=%0d alu=%b want 0 0 3 010", write_enable, mode, write_reg, alu_control); end
    checks++; if (read_reg_num1 !== 5'd1 || read_reg_num2 !== 5'd2) begin errors++; $display("FAIL alu_exec_rr got %0d %0d want 1 2", read_reg_num1, read_reg_num2); end
    @(negedge clock);
    checks++; if (write_enable !== 1'b1 || mode !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL alu_wb got we=%b mode=%b busy=%b want 1 1 1", write_enable, mode, busy); end
    @(negedge clock);
    checks++; if (write_enable !== 1'b0 || retired_cnt !== 16'd1 || instr_addr !== 8'h01) begin errors++; $display("FAIL alu_after got we=%b cnt=%0d pc=%h want 0 1 01", write_enable, retired_cnt, instr_addr); end
  endtask

  task automatic test_imm();
    logic [31:0] w;
    bit to;
    w = enc(3'b001, 3'b000, 5'd7, 5'd0, 16'h00A5);
    exp_q.push_back(exp_rec(w, 8'h01));
    send(w, to);
    checks++; if (to) begin errors++; $display("FAIL imm_handshake got timeout want accept"); end
    checks++; if (imm_ctrl !== 1'b1 || immediate !== 16'h00A5 || lw_ctrl !== 1'b0 || sw_ctrl !== 1'b0) begin errors++; $display("FAIL imm_exec got ic=%b imm=%h lw=%b sw=%b want 1 00a5 0 0", imm_ctrl, immediate, lw_ctrl, sw_ctrl); end
    @(negedge clock);
    checks++; if (imm_ctrl !== 1'b1 || immediate !== 16'h00A5 || write_enable !== 1'b1 || lw_ctrl !== 1'b0 || sw_ctrl !== 1'b0) begin errors++; $display("FAIL imm_wb got ic=%b imm=%h we=%b lw=%b sw=%b want 1 00a5 1 0 0", imm_ctrl, immediate, write_enable, lw_ctrl, sw_ctrl); end
    @(negedge clock);
    checks++; if (retired_cnt !== 16'd2 || instr_addr !== 8'h02 || ctrl_vec !== 37'h0) begin errors++; $display("FAIL imm_after got cnt=%0d pc=%h ctrl=%h want 2 02 0", retired_cnt, instr_addr, ctrl_vec); end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    bit to;
    send(enc(3'b101, 3'b001, 5'd9, 5'd9, 16'h1234), to);
    checks++; if (to) begin errors++; $display("FAIL ill_handshake got timeout want accept"); end
    checks++; if (illegal_op !== 1'b1 || instr_addr !== 8'h03 || instr_ready !== 1'b1) begin errors++; $display("FAIL ill_flag got ill=%b pc=%h rdy=%b want 1 03 1", illegal_op, instr_addr, instr_ready); end
    checks++; if (write_enable !== 1'b0 || retired_cnt !== 16'd2 || ctrl_vec !== 37'h0) begin errors++; $display("FAIL ill_quiet got we=%b cnt=%0d ctrl=%h want 0 2 0", write_enable, retired_cnt, ctrl_vec); end
    w = enc(3'b000, 3'b001, 5'd4, 5'd5, {5'd6, 11'd0});
    exp_q.push_back(exp_rec(w, 8'h03));
    send(w, to);
    @(negedge clock);
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL ill_next_wb got we=%b want 1", write_enable); end
    @(negedge clock);
    checks++; if (retired_cnt !== 16'd3 || instr_addr !== 8'h04 || illegal_op !== 1'b1) begin errors++; $display("FAIL ill_next_after got cnt=%0d pc=%h ill=%b want 3 04 1", retired_cnt, instr_addr, illegal_op); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w_lw, w_sw;
    w_lw = enc(3'b010, 3'b011, 5'd8, 5'd9, {5'd10, 11'd0});
    w_sw = enc(3'b011, 3'b100, 5'd11, 5'd12, {5'd13, 11'd0});
    exp_q.push_back(exp_rec(w_lw, 8'h04));
    exp_q.push_back(exp_rec(w_sw, 8'h05));
    instr_data  = w_lw;
    instr_valid = 1'b1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", instr_ready); end
    @(negedge clock);
    checks++; if (lw_ctrl !== 1'b1 || sw_ctrl !== 1'b0 || imm_ctrl !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL b2b_lw got lw=%b sw=%b ic=%b rdy=%b want 1 0 0 0", lw_ctrl, sw_ctrl, imm_ctrl, instr_ready); end
    instr_data = w_sw;
    repeat (2) @(negedge clock);
    checks++; if (instr_ready !== 1'b1 || instr_addr !== 8'h05) begin errors++; $display("FAIL b2b_refetch got rdy=%b pc=%h want 1 05", instr_ready, instr_addr); end
    @(negedge clock);
    checks++; if (sw_ctrl !== 1'b1 || lw_ctrl !== 1'b0 || imm_ctrl !== 1'b0) begin errors++; $display("FAIL b2b_sw got sw=%b lw=%b ic=%b want 1 0 0", sw_ctrl, lw_ctrl, imm_ctrl); end
    instr_valid = 1'b0;
    instr_data  = 32'h0;
    repeat (2) @(negedge clock);
    checks++; if (retired_cnt !== 16'd5 || instr_addr !== 8'h06) begin errors++; $display("FAIL b2b_after got cnt=%0d pc=%h want 5 06", retired_cnt, instr_addr); end
  endtask

  task automatic test_wait_and_ignored_start();
    repeat (5) @(negedge clock);
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b1 || instr_addr !== 8'h06 || retired_cnt !== 16'd5 || write_enable !== 1'b0) begin errors++; $display("FAIL wait_idle got rdy=%b busy=%b pc=%h cnt=%0d we=%b want 1 1 06 5 0", instr_ready, busy, instr_addr, retired_cnt, write_enable); end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (instr_addr !== 8'h06 || illegal_op !== 1'b1) begin errors++; $display("FAIL start_ignored got pc=%h ill=%b want 06 1", instr_addr, illegal_op); end
  endtask

  task automatic test_halt();
    bit to;
    send(enc(3'b111, 3'b000, 5'd0, 5'd0, 16'h0), to);
    checks++; if (to) begin errors++; $display("FAIL halt_handshake got timeout want accept"); end
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || instr_ready !== 1'b0 || instr_addr !== 8'h06) begin errors++; $display("FAIL halt_state got halt=%b busy=%b rdy=%b pc=%h want 1 0 0 06", halted, busy, instr_ready, instr_addr); end
    repeat (3) @(negedge clock);
    checks++; if (halted !== 1'b1 || write_enable !== 1'b0 || ctrl_vec !== 37'h0) begin errors++; $display("FAIL halt_hold got halt=%b we=%b ctrl=%h want 1 0 0", halted, write_enable, ctrl_vec); end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++; if (halted !== 1'b0 || instr_addr !== 8'h00 || illegal_op !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL halt_restart got halt=%b pc=%h ill=%b rdy=%b want 0 00 0 1", halted, instr_addr, illegal_op, instr_ready); end
  endtask

  task automatic test_reset_in_wb();
    logic [31:0] w;
    bit to;
    w = enc(3'b000, 3'b111, 5'd20, 5'd21, {5'd22, 11'd0});
    exp_q.push_back(exp_rec(w, 8'h00));
    send(w, to);
    @(negedge clock);
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rstwb_in_wb got we=%b want 1", write_enable); end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    checks++; if (write_enable !== 1'b0 || busy !== 1'b0 || retired_cnt !== 16'd0 || ctrl_vec !== 37'h0 || instr_addr !== 8'h00) begin errors++; $display("FAIL rstwb_after got we=%b busy=%b cnt=%0d ctrl=%h pc=%h want 0 0 0 0 00", write_enable, busy, retired_cnt, ctrl_vec, instr_addr); end
  endtask

  task automatic test_start_with_valid();
    logic [31:0] w;
    w = enc(3'b000, 3'b101, 5'd30, 5'd29, {5'd28, 11'd0});
    exp_q.push_back(exp_rec(w, 8'h00));
    start       = 1'b1;
    instr_valid = 1'b1;
    instr_data  = w;
    @(negedge clock);
    start = 1'b0;
    checks++; if (instr_ready !== 1'b1 || busy !== 1'b1 || write_reg !== 5'd0) begin errors++; $display("FAIL sv_not_taken got rdy=%b busy=%b wr=%0d want 1 1 0", instr_ready, busy, write_reg); end
    @(negedge clock);
    instr_valid = 1'b0;
    instr_data  = 32'h0;
    checks++; if (write_reg !== 5'd30 || write_enable !== 1'b0) begin errors++; $display("FAIL sv_exec got wr=%0d we=%b want 30 0", write_reg, write_enable); end
    repeat (2) @(negedge clock);
    checks++; if (retired_cnt !== 16'd1 || instr_addr !== 8'h01) begin errors++; $display("FAIL sv_after got cnt=%0d pc=%h want 1 01", retired_cnt, instr_addr); end
  endtask

  task automatic test_wrap_saturate();
    logic [1:0] acc_addr[9];
    int acc_cyc[9];
    int n_acc, n_ret;
    bit done5;
    n_acc = 0; n_ret = 0; done5 = 1'b0;
    b_reset = 1'b1;
    @(negedge clock);
    b_reset = 1'b0;
    b_start = 1'b1;
    @(negedge clock);
    b_start = 1'b0;
    b_data  = enc(3'b000, 3'b001, 5'd1, 5'd2, {5'd3, 11'd0});
    b_valid = 1'b1;
    for (int c = 0; c < 60 && n_ret < 9; c++) begin
      if (b_we === 1'b1) n_ret++;
      if (b_ready === 1'b1 && n_ret == 5 && !done5) begin
        done5 = 1'b1;
        checks++; if (b_cnt !== 3'd5) begin errors++; $display("FAIL wrap_cnt5 got %0d want 5", b_cnt); end
      end
      if (b_ready === 1'b1) begin
        if (n_acc < 9) begin
          acc_addr[n_acc] = b_addr;
          acc_cyc[n_acc]  = c;
          n_acc++;
        end else begin
          b_valid = 1'b0;
        end
      end
      @(negedge clock);
    end
    b_valid = 1'b0;
    @(negedge clock);
    checks++; if (n_ret != 9 || n_acc != 9) begin errors++; $display("FAIL wrap_progress got ret=%0d acc=%0d want 9 9", n_ret, n_acc); end
    for (int i = 0; i < n_acc; i++) begin
      checks++; if (acc_addr[i] !== 2'(i % 4)) begin errors++; $display("FAIL wrap_addr%0d got %0d want %0d", i, acc_addr[i], i % 4); end
    end
    for (int i = 1; i < n_acc; i++) begin
      checks++; if (acc_cyc[i] - acc_cyc[i-1] != 3) begin errors++; $display("FAIL wrap_gap%0d got %0d want 3", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    checks++; if (b_cnt !== 3'd7 || b_addr !== 2'd1 || b_we !== 1'b0) begin errors++; $display("FAIL wrap_sat got cnt=%0d pc=%0d we=%b want 7 1 0", b_cnt, b_addr, b_we); end
  endtask

  task automatic test_retire_log();
    logic [44:0] e, o;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL log_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL log_entry got %h want %h", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = 32'h0;
    b_reset = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 32'h0;
    @(negedge clock);
    test_reset();
    test_alu();
    test_imm();
    test_illegal();
    test_back_to_back();
    test_wait_and_ignored_start();
    test_halt();
    test_reset_in_wb();
    test_start_with_valid();
    test_wrap_saturate();
    test_retire_log();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
